// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
// Stage count and parameter sanity are computed here so every user agrees on them.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int seg);
    return (seg >= 1) ? width / seg : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// One SEG-bit slice of the carry chain: purely combinational sum, carry-out
// and the carry into the slice MSB (needed for signed overflow on the top slice).
module adder_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic [SEG:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  assign o_sum  = w_full[SEG-1:0];
  assign o_cout = w_full[SEG];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the MSB sum.
  assign o_cmsb = i_a[SEG-1] ^ i_b[SEG-1] ^ w_full[SEG-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit slice per stage, with
// skewed operands travelling forward and completed sum slices de-skewed behind.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("adder_pipe: WIDTH must be a positive multiple of SEG");
  end

  logic             w_stall;
  logic [WIDTH-1:0] w_bops;
  logic             w_c0;

  // Subtraction is a + ~b + 1; a borrow-in simply cancels the +1.
  assign w_bops   = b ^ {WIDTH{sub == MODE_SUB}};
  assign w_c0     = cin ^ (sub == MODE_SUB);
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;

    logic [SEG-1:0]    w_sa;
    logic [SEG-1:0]    w_sb;
    logic [SEG-1:0]    w_ss;
    logic              w_ci;
    logic              w_co;
    logic              w_cmsb;
    logic              w_vin;
    logic [LO+SEG-1:0] w_sum_next;
    logic [LO+SEG-1:0] r_sum;
    logic              r_carry;
    logic              r_valid;

    if (gi == 0) begin : g_head
      assign w_vin      = in_valid;
      assign w_sa       = a[SEG-1:0];
      assign w_sb       = w_bops[SEG-1:0];
      assign w_ci       = w_c0;
      assign w_sum_next = w_ss;
    end else begin : g_body
      assign w_vin      = g_stage[gi-1].r_valid;
      assign w_sa       = g_stage[gi-1].g_skew.r_a[SEG-1:0];
      assign w_sb       = g_stage[gi-1].g_skew.r_b[SEG-1:0];
      assign w_ci       = g_stage[gi-1].r_carry;
      assign w_sum_next = {w_ss, g_stage[gi-1].r_sum};
    end

    adder_slice #(.SEG(SEG)) u_slice (
      .i_a   (w_sa),
      .i_b   (w_sb),
      .i_cin (w_ci),
      .o_sum (w_ss),
      .o_cout(w_co),
      .o_cmsb(w_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (!w_stall) begin
        r_valid <= w_vin;
        if (w_vin) begin
          r_carry <= w_co;
          r_sum   <= w_sum_next;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      localparam int SW = WIDTH - LO - SEG;

      logic [SW-1:0] w_a_next;
      logic [SW-1:0] w_b_next;
      logic [SW-1:0] r_a;
      logic [SW-1:0] r_b;
      logic          w_unused_cmsb;

      assign w_unused_cmsb = w_cmsb;

      if (gi == 0) begin : g_src_in
        assign w_a_next = a[WIDTH-1:SEG];
        assign w_b_next = w_bops[WIDTH-1:SEG];
      end else begin : g_src_prev
        assign w_a_next = g_stage[gi-1].g_skew.r_a[SW+SEG-1:SEG];
        assign w_b_next = g_stage[gi-1].g_skew.r_b[SW+SEG-1:SEG];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall && w_vin) begin
          r_a <= w_a_next;
          r_b <= w_b_next;
        end
      end
    end else begin : g_tail
      logic r_ovf;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (!w_stall && w_vin) begin
          r_ovf <= w_co ^ w_cmsb;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_carry;
  assign overflow  = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a 16-bit/4-stage instance and a 3-bit/3-stage
// instance, both checked against a plain-integer a+-b+-cin reference model.
module tb_adder_pipe;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] sum;
  } exp_t;

  localparam int ST16 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, or16 = 1'b1, c16 = 1'b0, s16 = 1'b0;
  logic        ir16, ov16, co16, of16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        iv3 = 1'b0, or3 = 1'b1, c3 = 1'b0, s3 = 1'b0;
  logic        ir3, ov3, co3, of3;
  logic [2:0]  a3 = '0, b3 = '0, sum3;

  exp_t q16[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   bp_on    = 1'b0;

  adder_pipe #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(c16), .sub(s16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(co16), .overflow(of16)
  );

  adder_pipe #(.WIDTH(3), .SEG(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .cin(c3), .sub(s3), .out_valid(ov3), .out_ready(or3), .sum(sum3),
    .cout(co3), .overflow(of3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^w.
  function automatic exp_t model(input int w, input int av, input int bv, input int c, input int s);
    exp_t e;
    int   half, full, sa, sb, sres;
    half   = 1 << (w - 1);
    full   = (s != 0) ? av - bv - c : av + bv + c;
    sa     = (av >= half) ? av - 2 * half : av;
    sb     = (bv >= half) ? bv - 2 * half : bv;
    sres   = (s != 0) ? sa - sb - c : sa + sb + c;
    e.sum  = 16'(full & (2 * half - 1));
    e.cout = (s != 0) ? (full >= 0) : (full >= 2 * half);
    e.ovf  = (sres < -half) || (sres >= half);
    return e;
  endfunction

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
    int t = 0;
    a16 = av; b16 = bv; c16 = c; s16 = s; iv16 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (ir16) break;
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        n_checks++;
        $display("FAIL send16_timeout: in_ready stuck at 0");
        iv16 = 1'b0;
        return;
      end
    end
    q16.push_back(model(16, int'(av), int'(bv), int'(c), int'(s)));
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic send3(input logic [2:0] av, input logic [2:0] bv, input logic c, input logic s);
    int t = 0;
    a3 = av; b3 = bv; c3 = c; s3 = s; iv3 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (ir3) break;
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        n_checks++;
        $display("FAIL send3_timeout: in_ready stuck at 0");
        iv3 = 1'b0;
        return;
      end
    end
    q3.push_back(model(3, int'(av), int'(bv), int'(c), int'(s)));
    @(posedge clk); #1;
    iv3 = 1'b0;
  endtask

  task automatic drain(input bit w16);
    int t = 0;
    while (((w16 ? q16.size() : q3.size()) != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      $display("FAIL drain: %0d results never appeared", w16 ? q16.size() : q3.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic latency16();
    for (int i = 0; i < ST16; i++) begin
      @(negedge clk);
      check("latency_out_valid", {31'b0, ov16}, {31'b0, i == ST16 - 1});
    end
  endtask

  // Monitor for the 16-bit instance: handshake rules, stall stability, scoreboard.
  initial begin
    logic        prev_stall = 1'b0;
    logic        p_ov, p_co, p_of;
    logic [15:0] p_sum;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready16", {31'b0, ir16}, {31'b0, !(ov16 && !or16)});
        if (prev_stall) begin
          check("hold_valid", {31'b0, ov16}, {31'b0, p_ov});
          check("hold_sum", {16'b0, sum16}, {16'b0, p_sum});
          check("hold_cout", {31'b0, co16}, {31'b0, p_co});
          check("hold_ovf", {31'b0, of16}, {31'b0, p_of});
        end
        if (ov16 && or16) begin
          if (q16.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected16: result sum=%0h with nothing outstanding", sum16);
          end else begin
            e = q16.pop_front();
            check("sum16", {16'b0, sum16}, {16'b0, e.sum});
            check("cout16", {31'b0, co16}, {31'b0, e.cout});
            check("ovf16", {31'b0, of16}, {31'b0, e.ovf});
          end
        end
        prev_stall = ov16 && !or16;
        p_ov = ov16; p_sum = sum16; p_co = co16; p_of = of16;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov3 && or3) begin
        if (q3.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected3: result sum=%0h with nothing outstanding", sum3);
        end else begin
          e = q3.pop_front();
          check("sum3", {29'b0, sum3}, {29'b0, e.sum[2:0]});
          check("cout3", {31'b0, co3}, {31'b0, e.cout});
          check("ovf3", {31'b0, of3}, {31'b0, e.ovf});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready16", {31'b0, ir16}, 32'd1);
    check("reset_out_valid16", {31'b0, ov16}, 32'd0);
    check("reset_sum16", {16'b0, sum16}, 32'd0);
    check("reset_in_ready3", {31'b0, ir3}, 32'd1);
    check("reset_out_valid3", {31'b0, ov3}, 32'd0);

    // Wrap-around add with latency check
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    latency16();
    drain(1'b1);

    // Signed overflow, then subtract with borrow
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send16(16'h0003, 16'h0005, 1'b0, 1'b1);
    drain(1'b1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'b0, ov16}, 32'd0);
    check("async_rst_sum", {16'b0, sum16}, 32'd0);
    check("async_rst_cout", {31'b0, co16}, 32'd0);
    check("async_rst_ovf", {31'b0, of16}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_in_ready", {31'b0, ir16}, 32'd1);

    // Back-to-back stream with a 3-cycle sink stall
    fork
      begin
        for (int i = 0; i < 8; i++) send16(16'(i), 16'h0100, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 or16 = 1'b1;
      end
    join
    drain(1'b1);
    check("stream_none_lost", q16.size(), 32'd0);

    // Reset with three operations in flight
    send16(16'h1111, 16'h2222, 1'b0, 1'b0);
    send16(16'h3333, 16'h4444, 1'b1, 1'b0);
    send16(16'h5555, 16'h0001, 1'b0, 1'b1);
    #2 rst = 1'b1;
    q16.delete();
    #1 check("flush_out_valid", {31'b0, ov16}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flushed_no_output", {31'b0, ov16}, 32'd0);
    end
    @(posedge clk); #1;
    send16(16'h1234, 16'h1111, 1'b1, 1'b0);
    latency16();
    drain(1'b1);

    // Randomised operands, gaps and backpressure
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          or16 = ($urandom_range(0, 3) != 0);
        end
        or16 = 1'b1;
      end
    join
    drain(1'b1);
    check("random_none_lost", q16.size(), 32'd0);

    // Exhaustive 3-bit, single-bit slices, streamed at full rate
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 128; x++) begin
        send3(3'(x >> 4), 3'(x >> 1), 1'(x), 1'(s));
      end
    end
    drain(1'b0);
    check("exhaustive_none_lost", q3.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
